// File: rtl/phase_det.sv
// Edge-timing phase detector: counts clk cycles from each ref rise to the next fb rise.
// Define PHASE_DET_SYNC_EN to add a 2-flop synchronizer ahead of the sampling registers.
module phase_det #(
    parameter int PHASE_WIDTH = 10
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   ref_i,
    input  logic                   fb_i,
    output logic [PHASE_WIDTH-1:0] phase_o,
    output logic                   valid_o,
    output logic                   lost_o,
    output logic                   slip_o
);

    localparam logic [PHASE_WIDTH-1:0] MAX = '1;
    localparam logic [PHASE_WIDTH-1:0] ONE = PHASE_WIDTH'(1);

    typedef enum logic {IDLE, COUNT} state_t;

    logic ref_in, fb_in;

`ifdef PHASE_DET_SYNC_EN
    logic [1:0] ref_sync_q, ref_sync_d;
    logic [1:0] fb_sync_q, fb_sync_d;

    always_comb begin
        ref_sync_d = {ref_sync_q[0], ref_i};
        fb_sync_d  = {fb_sync_q[0], fb_i};
    end

    // Reset high so an input already high at release is not mistaken for a rise.
    always_ff @(posedge clk) begin
        if (rst) begin
            ref_sync_q <= 2'b11;
            fb_sync_q  <= 2'b11;
        end else begin
            ref_sync_q <= ref_sync_d;
            fb_sync_q  <= fb_sync_d;
        end
    end

    assign ref_in = ref_sync_q[1];
    assign fb_in  = fb_sync_q[1];
`else
    assign ref_in = ref_i;
    assign fb_in  = fb_i;
`endif

    logic ref_s_q, ref_s_d, ref_p_q, ref_p_d;
    logic fb_s_q, fb_s_d, fb_p_q, fb_p_d;
    logic ref_rise, fb_rise;

    state_t                 state_q, state_d;
    logic [PHASE_WIDTH-1:0] cnt_q, cnt_d;
    logic [PHASE_WIDTH-1:0] phase_q, phase_d;
    logic                   valid_q, valid_d;
    logic                   lost_q, lost_d;
    logic                   slip_q, slip_d;

    always_comb begin
        ref_s_d = ref_in;
        fb_s_d  = fb_in;
        ref_p_d = ref_s_q;
        fb_p_d  = fb_s_q;
    end

    assign ref_rise = ref_s_q & ~ref_p_q;
    assign fb_rise  = fb_s_q & ~fb_p_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            ref_s_q <= 1'b1;
            fb_s_q  <= 1'b1;
            ref_p_q <= 1'b1;
            fb_p_q  <= 1'b1;
            state_q <= IDLE;
            cnt_q   <= '0;
            phase_q <= '0;
            valid_q <= 1'b0;
            lost_q  <= 1'b0;
            slip_q  <= 1'b0;
        end else begin
            ref_s_q <= ref_s_d;
            fb_s_q  <= fb_s_d;
            ref_p_q <= ref_p_d;
            fb_p_q  <= fb_p_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
            valid_q <= valid_d;
            lost_q  <= lost_d;
            slip_q  <= slip_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (ref_rise && !fb_rise) state_d = COUNT;
            end
            COUNT: begin
                if (fb_rise)            state_d = ref_rise ? COUNT : IDLE;
                else if (ref_rise)      state_d = COUNT;
                else if (cnt_q == MAX)  state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // fb completes a measurement before a coincident ref restarts the next one.
    always_comb begin
        cnt_d   = cnt_q;
        phase_d = phase_q;
        valid_d = 1'b0;
        lost_d  = 1'b0;
        slip_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (ref_rise && fb_rise) begin
                    phase_d = '0;
                    valid_d = 1'b1;
                end else if (ref_rise) begin
                    cnt_d = ONE;
                end
            end
            COUNT: begin
                if (fb_rise) begin
                    phase_d = cnt_q;
                    valid_d = 1'b1;
                    if (ref_rise) cnt_d = ONE;
                end else if (ref_rise) begin
                    slip_d = 1'b1;
                    cnt_d  = ONE;
                end else if (cnt_q == MAX) begin
                    phase_d = MAX;
                    valid_d = 1'b1;
                    lost_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + ONE;
                end
            end
            default: ;
        endcase
    end

    assign phase_o = phase_q;
    assign valid_o = valid_q;
    assign lost_o  = lost_q;
    assign slip_o  = slip_q;

endmodule

// File: tb/tb_phase_det.sv
// Bench for phase_det: directed scenarios plus random pulse trains, checked cycle by cycle
// against a timestamp-based model (measured delay = fb time - ref time).
module tb_phase_det;

    localparam int PW   = 10;
    localparam int MAXV = (1 << PW) - 1;
    localparam int N    = 6000;
`ifdef PHASE_DET_SYNC_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 1;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          ref_i, fb_i;
    logic [PW-1:0] phase_o;
    logic          valid_o, lost_o, slip_o;

    phase_det #(.PHASE_WIDTH(PW)) dut (
        .clk     (clk),
        .rst     (rst),
        .ref_i   (ref_i),
        .fb_i    (fb_i),
        .phase_o (phase_o),
        .valid_o (valid_o),
        .lost_o  (lost_o),
        .slip_o  (slip_o)
    );

    always #5 clk = ~clk;

    bit ref_arr [N];
    bit fb_arr  [N];
    bit rst_arr [N];

    bit      exp_valid [N + LAT + 1];
    bit      exp_lost  [N + LAT + 1];
    bit      exp_slip  [N + LAT + 1];
    bit      exp_rst   [N + LAT + 1];
    int      exp_pval  [N + LAT + 1];
    int      exp_phase [N + LAT + 1];

    int tests = 0;
    int fails = 0;

    task automatic pulse(input int t_ref, input int t_fb);
        if (t_ref >= 0) ref_arr[t_ref] = 1'b1;
        if (t_fb >= 0)  fb_arr[t_fb]   = 1'b1;
    endtask

    initial begin
        bit pend;
        int start;
        bit prev_r, prev_f, rf, ff;
        int hold;
        logic [PW-1:0] want_phase;

        // ---------------- stimulus construction ----------------
        for (int t = 0; t < N; t++) begin
            ref_arr[t] = 1'b0;
            fb_arr[t]  = 1'b0;
            rst_arr[t] = 1'b0;
        end
        for (int t = 0; t < 20; t++) begin
            ref_arr[t] = 1'b1;
            fb_arr[t]  = 1'b1;
        end
        for (int k = 1; k <= 3; k++) pulse(100 * k, 100 * k + 37);
        pulse(450, 450);
        pulse(500, -1);
        pulse(530, 530);
        pulse(-1, 540);
        pulse(600, -1);
        pulse(-1, 1800);
        pulse(1900, -1);
        pulse(1950, 1970);
        pulse(2100, -1);
        rst_arr[2110] = 1'b1;
        pulse(2130, 2135);
        for (int t = 2200; t < 5800; t++) begin
            ref_arr[t] = ref_arr[t-1] ? bit'($urandom_range(1)) : ($urandom_range(59) == 0);
            fb_arr[t]  = fb_arr[t-1]  ? bit'($urandom_range(1)) : ($urandom_range(39) == 0);
        end

        // ---------------- reference model ----------------
        for (int e = 0; e < N + LAT + 1; e++) begin
            exp_valid[e] = 0; exp_lost[e] = 0; exp_slip[e] = 0;
            exp_rst[e] = 0; exp_pval[e] = 0; exp_phase[e] = 0;
        end
        pend = 0; start = 0; prev_r = 1; prev_f = 1;
        for (int t = 0; t < N; t++) begin
            if (rst_arr[t]) begin
                pend = 0; prev_r = 1; prev_f = 1;
                exp_rst[t] = 1;
                continue;
            end
            rf = ref_arr[t] && !prev_r;
            ff = fb_arr[t] && !prev_f;
            prev_r = ref_arr[t];
            prev_f = fb_arr[t];
            if (!pend) begin
                if (rf && ff) begin
                    exp_valid[t+LAT] = 1; exp_pval[t+LAT] = 0;
                end else if (rf) begin
                    pend = 1; start = t;
                end
            end else if (ff) begin
                exp_valid[t+LAT] = 1; exp_pval[t+LAT] = t - start;
                if (rf) start = t; else pend = 0;
            end else if (rf) begin
                exp_slip[t+LAT] = 1; start = t;
            end else if (t - start == MAXV) begin
                exp_valid[t+LAT] = 1; exp_lost[t+LAT] = 1; exp_pval[t+LAT] = MAXV;
                pend = 0;
            end
        end
        hold = 0;
        for (int e = 0; e < N + LAT + 1; e++) begin
            if (exp_rst[e]) hold = 0;
            else if (exp_valid[e]) hold = exp_pval[e];
            exp_phase[e] = hold;
        end

        // ---------------- run ----------------
        rst = 1'b1; ref_i = 1'b1; fb_i = 1'b1;
        repeat (5) @(negedge clk);
        for (int t = 0; t < N; t++) begin
            @(negedge clk);
            if (t > 0) begin
                want_phase = PW'(exp_phase[t-1]);
                tests++;
                assert (valid_o === exp_valid[t-1]) else begin
                    fails++;
                    $error("FAIL valid edge=%0d got=%b exp=%b", t - 1, valid_o, exp_valid[t-1]);
                end
                tests++;
                assert (lost_o === exp_lost[t-1]) else begin
                    fails++;
                    $error("FAIL lost edge=%0d got=%b exp=%b", t - 1, lost_o, exp_lost[t-1]);
                end
                tests++;
                assert (slip_o === exp_slip[t-1]) else begin
                    fails++;
                    $error("FAIL slip edge=%0d got=%b exp=%b", t - 1, slip_o, exp_slip[t-1]);
                end
                tests++;
                assert (phase_o === want_phase) else begin
                    fails++;
                    $error("FAIL phase edge=%0d got=%0d exp=%0d", t - 1, phase_o, want_phase);
                end
            end
            rst   = rst_arr[t];
            ref_i = ref_arr[t];
            fb_i  = fb_arr[t];
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
